// File: rtl/dmac_pkg.sv
// dmac_pkg: DMAC-wide defaults shared between the engine and its data-path FIFO
package dmac_pkg;
  localparam int DMAC_FIFO_DEPTH_LG2 = 4;
  localparam int DMAC_FIFO_DATA_WIDTH = 32;
endpackage

// File: rtl/dmac_fifo_mem.sv
// dmac_fifo_mem: register-array FIFO storage, one write port, combinational write-through read port
module dmac_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/dmac_fifo_lvl.sv
// dmac_fifo_lvl: FWFT FIFO with occupancy, almost-full/empty flags, flush and sticky error flags
module dmac_fifo_lvl
  import dmac_pkg::*;
#(
  parameter int DEPTH_LG2 = DMAC_FIFO_DEPTH_LG2,
  parameter int DATA_WIDTH = DMAC_FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  afull_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  aempty_o,
  input  logic [DEPTH_LG2:0]    afull_thr_i,
  input  logic [DEPTH_LG2:0]    aempty_thr_i,
  output logic [DEPTH_LG2:0]    level_o,
  output logic                  ovf_o,
  output logic                  udf_o,
  input  logic                  err_clr_i
);
  localparam int PW = DEPTH_LG2 + 1;
  logic [PW-1:0] wrptr, rdptr, wrptr_n, rdptr_n, level_n;
  logic wr_acc, rd_acc, full_n, empty_n;
  logic [DATA_WIDTH-1:0] head_n;
  always_comb begin
    wr_acc = wren_i & ~full_o & ~flush_i;
    rd_acc = rden_i & ~empty_o & ~flush_i;
    wrptr_n = flush_i ? '0 : wrptr + PW'(wr_acc);
    rdptr_n = flush_i ? '0 : rdptr + PW'(rd_acc);
    level_n = wrptr_n - rdptr_n;
    empty_n = wrptr_n == rdptr_n;
    full_n = (wrptr_n[DEPTH_LG2] != rdptr_n[DEPTH_LG2]) &&
             (wrptr_n[DEPTH_LG2-1:0] == rdptr_n[DEPTH_LG2-1:0]);
  end
  // head is read at the next-state read pointer so rdata_o is already the new head after a pop
  dmac_fifo_mem #(.AW(DEPTH_LG2), .DW(DATA_WIDTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wrptr[DEPTH_LG2-1:0]),
    .wdata (wdata_i),
    .raddr (rdptr_n[DEPTH_LG2-1:0]),
    .rdata (head_n)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrptr <= '0;
      rdptr <= '0;
      level_o <= '0;
      full_o <= 1'b0;
      empty_o <= 1'b1;
      afull_o <= afull_thr_i == '0;
      aempty_o <= 1'b1;
      rdata_o <= '0;
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      wrptr <= wrptr_n;
      rdptr <= rdptr_n;
      level_o <= level_n;
      full_o <= full_n;
      empty_o <= empty_n;
      afull_o <= level_n >= afull_thr_i;
      aempty_o <= level_n <= aempty_thr_i;
      rdata_o <= head_n;
      ovf_o <= (wren_i & full_o & ~flush_i) | (ovf_o & ~err_clr_i);
      udf_o <= (rden_i & empty_o & ~flush_i) | (udf_o & ~err_clr_i);
    end
  end
endmodule

// File: tb/tb_dmac_fifo_lvl.sv
// tb_dmac_fifo_lvl: directed and randomized checks of dmac_fifo_lvl against a queue model
module tb_dmac_fifo_lvl;
  localparam int LG = 4;
  localparam int D = 16;
  logic clk = 0, rst_n = 0, flush_i = 0, wren_i = 0, rden_i = 0, err_clr_i = 0;
  logic [31:0] wdata_i = 0, rdata_o;
  logic full_o, afull_o, empty_o, aempty_o, ovf_o, udf_o;
  logic [LG:0] afull_thr_i = 12, aempty_thr_i = 3, level_o;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic m_ovf = 0, m_udf = 0;

  dmac_fifo_lvl #(.DEPTH_LG2(LG), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .wren_i(wren_i), .wdata_i(wdata_i),
    .full_o(full_o), .afull_o(afull_o), .rden_i(rden_i), .rdata_o(rdata_o),
    .empty_o(empty_o), .aempty_o(aempty_o), .afull_thr_i(afull_thr_i),
    .aempty_thr_i(aempty_thr_i), .level_o(level_o), .ovf_o(ovf_o), .udf_o(udf_o),
    .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;

  // apply one cycle of stimulus, advance the model, and return 1ns after the edge
  task automatic drive(input logic wr, input logic [31:0] wd, input logic rd, input logic fl, input logic clr);
    bit was_full, was_empty, so, su;
    wren_i = wr; wdata_i = wd; rden_i = rd; flush_i = fl; err_clr_i = clr;
    was_full = q.size() == D;
    was_empty = q.size() == 0;
    so = wr && was_full && !fl;
    su = rd && was_empty && !fl;
    if (fl) q.delete();
    else begin
      if (rd && !was_empty) void'(q.pop_front());
      if (wr && !was_full) q.push_back(wd);
    end
    m_ovf = so | (m_ovf & ~clr);
    m_udf = su | (m_udf & ~clr);
    @(posedge clk); #1;
    wren_i = 0; rden_i = 0; flush_i = 0; err_clr_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    wren_i = $urandom_range(0, 1); rden_i = $urandom_range(0, 1);
    @(posedge clk); #1;
    rst_n = 1; wren_i = 0; rden_i = 0;
    q.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic test_reset();
    afull_thr_i = 0;
    do_reset();
    checks++; if (afull_o !== 1'b1) begin errors++; $display("FAIL reset_afull_thr0 got %b want 1", afull_o); end
    afull_thr_i = 12;
    do_reset();
    checks++;
    if ({full_o, afull_o, empty_o, aempty_o, ovf_o, udf_o} !== 6'b001100 || level_o !== 0 || rdata_o !== 0) begin
      errors++;
      $display("FAIL reset_state got f%b af%b e%b ae%b o%b u%b lvl%0d rd%h want 0 0 1 1 0 0 0 0",
               full_o, afull_o, empty_o, aempty_o, ovf_o, udf_o, level_o, rdata_o);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      drive(1, i, 0, 0, 0);
      checks++; if (level_o !== i) begin errors++; $display("FAIL fill_level got %0d want %0d", level_o, i); end
      checks++; if (afull_o !== (i >= 12)) begin errors++; $display("FAIL fill_afull at %0d got %b", i, afull_o); end
      checks++; if (full_o !== (i == D)) begin errors++; $display("FAIL fill_full at %0d got %b", i, full_o); end
    end
    drive(1, 32'hdead, 0, 0, 0);
    checks++; if (ovf_o !== 1 || level_o !== D) begin errors++; $display("FAIL fill_overflow got ovf%b lvl%0d want 1 16", ovf_o, level_o); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= D; i++) begin
      checks++; if (rdata_o !== i) begin errors++; $display("FAIL drain_data got %h want %h", rdata_o, i); end
      drive(0, 0, 1, 0, 0);
    end
    checks++; if (empty_o !== 1 || level_o !== 0) begin errors++; $display("FAIL drain_empty got e%b lvl%0d want 1 0", empty_o, level_o); end
    checks++; if (udf_o !== 0) begin errors++; $display("FAIL drain_udf_early got %b want 0", udf_o); end
    drive(0, 0, 1, 0, 0);
    checks++; if (udf_o !== 1) begin errors++; $display("FAIL drain_underflow got %b want 1", udf_o); end
  endtask

  task automatic test_simul_empty();
    drive(0, 0, 0, 0, 1);
    checks++; if (ovf_o !== 0 || udf_o !== 0) begin errors++; $display("FAIL errclr got o%b u%b want 0 0", ovf_o, udf_o); end
    drive(1, 32'ha5, 1, 0, 0);
    checks++;
    if (udf_o !== 1 || rdata_o !== 32'ha5 || level_o !== 1 || empty_o !== 0) begin
      errors++; $display("FAIL simul_empty got u%b rd%h lvl%0d e%b want 1 a5 1 0", udf_o, rdata_o, level_o, empty_o);
    end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 14; i++) drive(1, $urandom, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, $urandom, 1, 0, 0);
      checks++; if (level_o !== 8) begin errors++; $display("FAIL wrap_level got %0d want 8", level_o); end
      checks++; if (rdata_o !== q[0]) begin errors++; $display("FAIL wrap_data got %h want %h", rdata_o, q[0]); end
    end
  endtask

  task automatic test_flush();
    logic po, pu;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 100 + i, 0, 0, 0);
    po = ovf_o; pu = udf_o;
    drive(1, 32'h77, 1, 1, 0);
    checks++; if (level_o !== 0 || empty_o !== 1 || full_o !== 0) begin errors++; $display("FAIL flush_state got lvl%0d e%b f%b want 0 1 0", level_o, empty_o, full_o); end
    checks++; if (ovf_o !== m_ovf || udf_o !== m_udf || ovf_o !== po || udf_o !== pu) begin errors++; $display("FAIL flush_errs got o%b u%b want %b %b", ovf_o, udf_o, po, pu); end
    drive(1, 32'h55, 0, 0, 0);
    checks++; if (rdata_o !== 32'h55 || level_o !== 1) begin errors++; $display("FAIL flush_refill got %h lvl%0d want 55 1", rdata_o, level_o); end
  endtask

  task automatic test_err_clr();
    drive(0, 0, 0, 1, 1);
    for (int i = 0; i < D; i++) drive(1, i, 0, 0, 0);
    checks++; if (ovf_o !== 0 || full_o !== 1) begin errors++; $display("FAIL errclr_setup got o%b f%b want 0 1", ovf_o, full_o); end
    drive(1, 0, 0, 0, 0);
    checks++; if (ovf_o !== 1) begin errors++; $display("FAIL errclr_ovf got %b want 1", ovf_o); end
    drive(1, 0, 0, 0, 1);
    checks++; if (ovf_o !== 1) begin errors++; $display("FAIL errclr_set_wins got %b want 1", ovf_o); end
    drive(0, 0, 0, 0, 1);
    checks++; if (ovf_o !== 0) begin errors++; $display("FAIL errclr_clear got %b want 0", ovf_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        afull_thr_i = LG'($urandom_range(0, 17));
        aempty_thr_i = LG'($urandom_range(0, 17));
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0);
      checks++;
      if (level_o !== q.size() || full_o !== (q.size() == D) || empty_o !== (q.size() == 0) ||
          afull_o !== (q.size() >= afull_thr_i) || aempty_o !== (q.size() <= aempty_thr_i) ||
          ovf_o !== m_ovf || udf_o !== m_udf || (q.size() != 0 && rdata_o !== q[0])) begin
        errors++;
        $display("FAIL random cyc%0d got lvl%0d f%b e%b af%b ae%b o%b u%b rd%h want lvl%0d o%b u%b rd%h",
                 i, level_o, full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o, rdata_o,
                 q.size(), m_ovf, m_udf, q.size() != 0 ? q[0] : 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simul_empty();
    test_wrap();
    test_flush();
    test_err_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmac_fifo_lvl.md
# dmac_fifo_lvl

Parametrised synchronous FIFO for the DMAC data path: the next generation of the engine's buffer. It adds an occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. It sits between the AXI read-data channel and the write-data channel, and feeds flow-control decisions (burst issue and abort) in the DMAC engine FSM.

## Interface
- DEPTH_LG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LG2; legal range 2..10
- DATA_WIDTH, 32, entry width in bits
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush_i  in  1  synchronous flush; discards all contents
- wren_i  in  1  write request
- wdata_i  in  DATA_WIDTH  write data
- full_o  out  1  no free entry
- afull_o  out  1  level_o >= afull_thr_i
- rden_i  in  1  read (pop) request
- rdata_o  out  DATA_WIDTH  head entry (first-word-fall-through); valid when empty_o=0
- empty_o  out  1  no valid entry
- aempty_o  out  1  level_o <= aempty_thr_i
- afull_thr_i  in  DEPTH_LG2+1  almost-full threshold; quasi-static
- aempty_thr_i  in  DEPTH_LG2+1  almost-empty threshold; quasi-static
- level_o  out  DEPTH_LG2+1  occupancy, 0..DEPTH
- ovf_o  out  1  sticky: write attempted while full
- udf_o  out  1  sticky: read attempted while empty
- err_clr_i  in  1  clears ovf_o and udf_o

## Operation
- Write is accepted iff wren_i & ~full_o. Read is accepted iff rden_i & ~empty_o. Both use the registered flags.
- Pointers wrptr and rdptr are DEPTH_LG2+1 bits and wrap modulo 2*DEPTH.
  - empty: pointers are equal.
  - full: MSBs differ and the low bits are equal.
  - level = wrptr - rdptr, computed modulo 2*DEPTH.
- Every output flag and level_o is registered and computed from the next-state pointers.
- rdata_o is registered from next-state storage, read at rdptr_next, so a word written into an empty FIFO is presented the following cycle.
- Simultaneous write and read:
  - When 0 < level < DEPTH, both are accepted and level is unchanged.
  - When full, the read is accepted and the write is rejected, raising ovf.
  - When empty, the write is accepted and the read is rejected, raising udf.
- Flush has priority over wren_i and rden_i:
  - Next state: pointers 0, level 0, empty_o=1, full_o=0.
  - Same-cycle write is discarded and ovf/udf are not raised.
  - Storage contents are not cleared.
- ovf_o sets on wren_i & full_o & ~flush_i. udf_o sets on rden_i & empty_o & ~flush_i.
  - Both hold until err_clr_i or reset.
  - If set and clear occur in the same cycle, set wins.
- Thresholds are sampled combinationally into the next-state flag computation.
  - afull_thr_i=0 makes afull_o constantly 1.
  - aempty_thr_i >= DEPTH makes aempty_o constantly 1.
- Storage array is not reset.

## Timing
- Reset values: full_o=0, afull_o=(afull_thr_i==0) from the first post-reset cycle, empty_o=1, aempty_o=1, level_o=0, rdata_o=0, ovf_o=0, udf_o=0.
- Write-to-read latency is 1 cycle: a write at edge N gives empty_o=0 and rdata_o=wdata after edge N.
- Read-to-next-head latency is 1 cycle: after a pop at edge N, the next entry is on rdata_o after edge N.
- full_o asserts at the edge that accepts the DEPTH-th outstanding write. empty_o asserts at the edge that pops the last entry.
- Reset mid-operation: all registered state returns to reset values at the next edge; in-flight requests are dropped.
- Throughput is 1 write and 1 read per cycle sustained, with no bubble at wrap-around.

## Structure
- dmac_pkg gains the DMAC_FIFO_DEPTH_LG2 and DMAC_FIFO_DATA_WIDTH defaults, shared with the engine.
- Sub-module dmac_fifo_mem is the DEPTH x DATA_WIDTH register array.
  - One write port.
  - One combinational read port, with write-through used for the next-state head.
- Pointer, level, flag and error logic lives in dmac_fifo_lvl.

## Test plan
- Reset, then write 0x1..0x10 on 16 back-to-back cycles:
  - full_o=1 and level_o=16 after the 16th write.
  - afull_o=1 from level 12 with thr=12.
  - A 17th write sets ovf_o and level stays 16.
- From full, read 16 times: data 0x1..0x10 in order, empty_o=1 after the last pop, and a 17th read sets udf_o.
- From empty, drive wren_i=rden_i=1 with 0xA5: the read is rejected and udf=1; the next cycle shows rdata_o=0xA5, level_o=1.
- At level 8 with wrptr near wrap, run 40 cycles of simultaneous read/write: level_o stays 8 and the data sequence is intact across the pointer wrap.
- At level 5, assert flush_i together with wren_i=1: the next cycle shows level_o=0 and empty_o=1, and ovf/udf are unchanged.
- With ovf_o=1, assert err_clr_i and wren_i while full in the same cycle: ovf_o stays 1. err_clr_i alone clears it.
